// File: rtl/elm_row_sequencer.sv
// Row sequencer for the ELM hidden layer: clears and runs the 9-tap counter/MAC once per
// neuron row, hands each finished row to the activation stage, and watchdogs the counter.
module elm_row_sequencer #(
  parameter int ROWS     = 3,
  parameter int ROW_W    = 2,
  parameter int WDOG_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             count9,
  input  logic             row_ready,
  output logic             rst_counter,
  output logic             en_counter,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             row_valid,
  output logic [ROW_W-1:0] row_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WD_W = $clog2(WDOG_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_MAX - 1);

  logic [2:0]       state;
  logic [ROW_W-1:0] row;
  logic [WD_W-1:0]  wdog;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      row   <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state <= S_CLR;
            row   <= '0;
          end
        end
        S_CLR: begin
          wdog  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // Saturating so a stuck counter can never wrap the watchdog back to a safe value.
          if (wdog != '1) wdog <= wdog + 1'b1;
          if (count9)              state <= S_LATCH;
          else if (wdog == WD_LAST) state <= S_ERR;
        end
        S_LATCH: begin
          if (row_ready) begin
            if (row == ROW_LAST) begin
              state <= S_DONE;
            end else begin
              row   <= row + 1'b1;
              state <= S_CLR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Enables are gated combinationally by count9 so the counter stops exactly on its 9th tap.
  assign en_counter  = (state == S_RUN) & ~count9;
  assign acc_en      = en_counter;
  assign rst_counter = (state == S_CLR);
  assign acc_clr     = (state == S_CLR);
  assign row_valid   = (state == S_LATCH);
  assign row_idx     = row;
  assign busy        = (state == S_CLR) | (state == S_RUN) | (state == S_LATCH) | (state == S_DONE);
  assign done        = (state == S_DONE);
  assign err         = (state == S_ERR);

endmodule

// File: tb/tb_elm_row_sequencer.sv
// Bench for elm_row_sequencer with a behavioural tap counter attached; checks row timing,
// backpressure, watchdog and reset behaviour against schedule rules.
module tb_elm_row_sequencer;

  localparam int ROWS  = 3;
  localparam int ROW_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b1;
  logic             count9;
  logic             row_ready = 1'b1;
  logic             rst_counter, en_counter, acc_clr, acc_en, row_valid, busy, done, err;
  logic [ROW_W-1:0] row_idx;

  int ntests = 0;
  int nfail  = 0;
  int stall_cfg [ROWS];

  // Behavioural tap counter; force_c9_low models a counter that never reaches 9.
  logic [3:0] cnt = 4'd0;
  logic       force_c9_low = 1'b0;
  assign count9 = force_c9_low ? 1'b0 : (cnt == 4'd9);
  always @(posedge clk) begin
    if (rst_counter)     cnt <= 4'd0;
    else if (en_counter) cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  end

  always #5 clk = ~clk;

  elm_row_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .WDOG_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .count9(count9), .row_ready(row_ready),
    .rst_counter(rst_counter), .en_counter(en_counter), .acc_clr(acc_clr), .acc_en(acc_en),
    .row_valid(row_valid), .row_idx(row_idx), .busy(busy), .done(done), .err(err)
  );

  wire [9:0] all_out = {rst_counter, en_counter, acc_clr, acc_en, row_valid, row_idx, busy, done, err};

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full run from IDLE/ERR; row r is held off for stall_cfg[r] LATCH cycles.
  task automatic do_run(input int pulse_cyc, input int exp_done, input string tag);
    int cyc, left, held, done_cyc;
    int en_cnt [ROWS];
    int acc_q [$];
    for (int i = 0; i < ROWS; i++) en_cnt[i] = 0;
    @(negedge clk);
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; left = -1; held = 0; done_cyc = -1;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_cyc);
      if (cyc == 1) chk({tag, " clr_entry"}, {27'd0, acc_clr, rst_counter, busy, err, row_valid}, 5'b11100);
      if (en_counter && int'(row_idx) < ROWS) en_cnt[row_idx]++;
      if (en_counter && (row_valid || !busy)) chk({tag, " en_outside_run"}, 1, 0);
      if (row_valid) begin
        if (left < 0) begin
          left = stall_cfg[row_idx];
          held = row_idx;
        end else begin
          chk({tag, " row_idx_held"}, row_idx, held);
        end
        row_ready = (left == 0);
        if (left == 0) begin
          acc_q.push_back(int'(row_idx));
          left = -1;
        end else begin
          left--;
        end
      end else begin
        row_ready = 1'($urandom_range(0, 1));
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0; row_ready = 1'b1;
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    for (int i = 0; i < ROWS; i++) chk({tag, " en_per_row"}, en_cnt[i], 9);
    chk({tag, " rows_accepted"}, acc_q.size(), ROWS);
    for (int i = 0; i < acc_q.size(); i++) chk({tag, " row_order"}, acc_q[i], i);
    @(negedge clk);
    chk({tag, " busy_after_done"}, {30'd0, busy, done}, 0);
  endtask

  typedef struct {
    string name;
    int    s0, s1, s2;
    int    pulse;
    int    exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc, nen, errc, exp_d, pulse;

    vecs[0] = '{"nominal",        0, 0, 0, -1, 37};
    vecs[1] = '{"bp_row1_5",      0, 5, 0, -1, 42};
    vecs[2] = '{"start_in_run",   0, 0, 0,  5, 37};
    vecs[3] = '{"start_in_latch", 0, 0, 0, 12, 37};
    vecs[4] = '{"bp_mixed",       2, 0, 3, 20, 42};

    // Reset with start held high: nothing may leave IDLE.
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", all_out, 0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", all_out, 0);

    foreach (vecs[v]) begin
      stall_cfg[0] = vecs[v].s0; stall_cfg[1] = vecs[v].s1; stall_cfg[2] = vecs[v].s2;
      do_run(vecs[v].pulse, vecs[v].exp_done, vecs[v].name);
    end

    // Watchdog: counter never reaches 9.
    force_c9_low = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; nen = 0; errc = -1;
    while (cyc < 60 && errc < 0) begin
      @(negedge clk);
      cyc++;
      if (en_counter) nen++;
      if (err) errc = cyc;
    end
    chk("wdog_err_cycle", errc, 17);
    chk("wdog_run_enables", nen, 15);
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", err, 1);
      chk("err_strobes_low", {rst_counter, en_counter, acc_clr, acc_en, row_valid, busy, done}, 0);
    end
    force_c9_low = 1'b0;
    for (int i = 0; i < ROWS; i++) stall_cfg[i] = 0;
    do_run(-1, 37, "after_err");

    // Reset in the middle of row 1.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", all_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset_idle", all_out, 0);
    do_run(-1, 37, "after_midrun_rst");

    // Random backpressure and stray start pulses; done = 12 cycles per row + stalls + 1.
    for (int k = 0; k < 6; k++) begin
      exp_d = 12 * ROWS + 1;
      for (int i = 0; i < ROWS; i++) begin
        stall_cfg[i] = $urandom_range(0, 4);
        exp_d += stall_cfg[i];
      end
      pulse = $urandom_range(2, 30);
      do_run(pulse, exp_d, "random");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
